spi_ram_ctrl: RTL and testbench

//  Memory-side stage of the 16-bit CPU: turns single-word read/write requests from the

---
 rtl/spi_ram_ctrl.sv | 128 ++++++++++++
 tb/tb_spi_ram_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_ctrl.sv
// Serial-RAM controller: one 16-bit word per request as an SPI mode-0 READ/WRITE frame.
// Latency: accept edge -> rsp_valid in cycle 2N+1 (97 cycles at ADDR_BITS=24).
// Backpressure: req_ready is high only in IDLE; requests are ignored while a frame runs.
module spi_ram_ctrl #(
    parameter int         ADDR_BITS = 24,
    parameter logic [7:0] CMD_READ  = 8'h03,
    parameter logic [7:0] CMD_WRITE = 8'h02
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        busy,
    output logic        spi_select,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    // Frame = opcode | byte address | 16 data bits.
    localparam int N  = 24 + ADDR_BITS;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_BIT  = CW'(N - 1);
    localparam logic [CW-1:0] DATA_BIT0 = CW'(N - 16);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t                 state;
    logic [N-1:0]           tx_sr;
    logic [15:0]            rx_sr;
    logic [CW-1:0]          bit_cnt;
    logic                   phase;
    logic                   is_write;

    logic [23:0]            addr_wide;
    logic [ADDR_BITS-1:0]   addr_field;
    logic [N-1:0]           frame;

    // Build the outgoing frame from the request; word address becomes a byte address.
    always_comb begin
        addr_wide  = {7'b0, req_addr, 1'b0};
        addr_field = addr_wide[ADDR_BITS-1:0];
        frame      = {(req_write ? CMD_WRITE : CMD_READ), addr_field,
                      (req_write ? req_wdata : 16'h0000)};
    end

    // Transaction FSM: two clk cycles per SPI bit (SCK low then high), then one DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            spi_select <= 1'b1;
            spi_clk    <= 1'b0;
            spi_mosi   <= 1'b0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            bit_cnt    <= '0;
            phase      <= 1'b0;
            is_write   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        state      <= SHIFT;
                        req_ready  <= 1'b0;
                        busy       <= 1'b1;
                        is_write   <= req_write;
                        spi_select <= 1'b0;
                        spi_clk    <= 1'b0;
                        spi_mosi   <= frame[N-1];
                        tx_sr      <= {frame[N-2:0], 1'b0};
                        bit_cnt    <= '0;
                        phase      <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (!phase) begin
                        // Rising SCK; MOSI stays put for the whole bit.
                        spi_clk <= 1'b1;
                        phase   <= 1'b1;
                    end else begin
                        // End of the high phase: sample MISO, then drop SCK.
                        phase   <= 1'b0;
                        spi_clk <= 1'b0;
                        if (bit_cnt >= DATA_BIT0) begin
                            rx_sr <= {rx_sr[14:0], spi_miso};
                        end
                        if (bit_cnt == LAST_BIT) begin
                            state      <= DONE;
                            spi_select <= 1'b1;
                            spi_mosi   <= 1'b0;
                            rsp_valid  <= 1'b1;
                            if (!is_write) begin
                                rsp_rdata <= {rx_sr[14:0], spi_miso};
                            end
                        end else begin
                            bit_cnt  <= bit_cnt + CW'(1);
                            spi_mosi <= tx_sr[N-1];
                            tx_sr    <= {tx_sr[N-2:0], 1'b0};
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Bench for spi_ram_ctrl: frame-level model, per-cycle output compare, SPI slave model.
// Latency: checks rsp_valid at cycle 97 after the accept edge.
// Backpressure: holds req_valid through busy periods to check acceptance timing.
module tb_spi_ram_ctrl;

    localparam int NB = 48;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        busy;
    logic        spi_select;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;

    int total = 0;
    int bad = 0;

    spi_ram_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .spi_select(spi_select), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out", name);
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] miso_word = 16'h0000;
    int          edge_cnt = 0;
    logic        m_act = 1'b0;
    int          m_cyc = 0;
    logic [NB-1:0] m_frame = '0;
    logic        m_write = 1'b0;
    logic [15:0] m_word = '0;
    logic [15:0] m_rdata = '0;
    int          acc_q[$];

    // Model advances one clock: cycle index within the frame, read data on completion.
    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        if (!rst && req_valid && req_ready) acc_q.push_back(edge_cnt + 1);
        if (rst) begin
            m_act   <= 1'b0;
            m_rdata <= '0;
        end else if (m_act) begin
            m_cyc <= m_cyc + 1;
            if (m_cyc + 1 == 2 * NB + 1 && !m_write) m_rdata <= m_word;
            if (m_cyc + 1 == 2 * NB + 2) m_act <= 1'b0;
        end else if (req_valid) begin
            m_act   <= 1'b1;
            m_cyc   <= 1;
            m_write <= req_write;
            m_word  <= miso_word;
            m_frame <= {(req_write ? 8'h02 : 8'h03), 24'(req_addr) * 24'd2,
                        (req_write ? req_wdata : 16'h0000)};
        end
    end

    // Expected {select, sck, mosi, rsp_valid, busy, ready} for the current cycle.
    function automatic logic [5:0] exp_vec();
        if (!m_act) return 6'b100001;
        if (m_cyc <= 2 * NB)
            return {1'b0, (m_cyc % 2 == 0), m_frame[NB - 1 - (m_cyc - 1) / 2], 1'b0, 1'b1, 1'b0};
        return 6'b100110;
    endfunction

    // ---------------- per-cycle compare and run-length monitors ----------------
    logic prev_sel = 1'b1;
    int   low_run = 0, high_run = 0, last_low = 0, last_gap = 0;
    int   rsp_cnt = 0, rsp_edge = 0;

    // Compare all outputs against the model on the falling edge.
    always @(negedge clk) begin
        chk("cyc_select", spi_select, exp_vec() >> 5);
        chk("cyc_sck", spi_clk, (exp_vec() >> 4) & 6'd1);
        chk("cyc_mosi", spi_mosi, (exp_vec() >> 3) & 6'd1);
        chk("cyc_rsp_valid", rsp_valid, (exp_vec() >> 2) & 6'd1);
        chk("cyc_busy", busy, (exp_vec() >> 1) & 6'd1);
        chk("cyc_ready", req_ready, exp_vec() & 6'd1);
        chk("cyc_rdata", rsp_rdata, m_rdata);
        if (!spi_select) begin
            low_run <= prev_sel ? 1 : low_run + 1;
            if (prev_sel) last_gap <= high_run;
        end else begin
            high_run <= prev_sel ? high_run + 1 : 1;
            if (!prev_sel) last_low <= low_run;
        end
        prev_sel <= spi_select;
        if (rsp_valid) begin
            rsp_cnt  <= rsp_cnt + 1;
            rsp_edge <= edge_cnt;
        end
    end

    // ---------------- SPI slave model ----------------
    int            s_cnt = 0;
    logic [NB-1:0] s_rx = '0;
    logic [NB-1:0] last_rx = '0;
    int            last_cnt = 0;
    logic          abort = 1'b0;

    // Capture MOSI on SCK rise, present the next read bit; check the frame when CS rises.
    always @(posedge spi_clk or posedge spi_select) begin
        if (spi_select) begin
            if (s_cnt != 0 && !abort) begin
                chk("frame_sck_rises", s_cnt, NB);
                chk("frame_mosi", s_rx, m_frame);
            end
            last_rx  <= s_rx;
            last_cnt <= s_cnt;
            s_cnt    <= 0;
            s_rx     <= '0;
        end else begin
            s_cnt    <= s_cnt + 1;
            s_rx     <= {s_rx[NB-2:0], spi_mosi};
            spi_miso <= (s_cnt >= NB - 16) ? miso_word[15 - (s_cnt - (NB - 16))] : 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_acc(input int target, input string name);
        for (int i = 0; i < 300 && acc_q.size() < target; i++) @(negedge clk);
        if (acc_q.size() < target) fail_now(name);
    endtask

    task automatic send(input logic w, input logic [15:0] a, input logic [15:0] d);
        int n0;
        n0 = acc_q.size();
        req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
        wait_acc(n0 + 1, "accept_timeout");
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n0;
        n0 = rsp_cnt;
        for (int i = 0; i < 300 && rsp_cnt == n0; i++) @(negedge clk);
        if (rsp_cnt == n0) fail_now("rsp_timeout");
    endtask

    initial begin
        int n0;
        repeat (3) @(negedge clk);
        chk("reset_select", spi_select, 1);
        chk("reset_sck", spi_clk, 0);
        chk("reset_mosi", spi_mosi, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rdata", rsp_rdata, 0);
        chk("reset_busy", busy, 0);
        chk("reset_ready", req_ready, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: write 0x0012 <- 0xBEEF
        send(1'b1, 16'h0012, 16'hBEEF);
        wait_rsp();
        chk("t1_latency", rsp_edge - acc_q[$] + 1, 97);
        chk("t1_frame", last_rx, 48'h0200_0024_BEEF);
        chk("t1_cs_low", last_low, 96);
        chk("t1_sck_rises", last_cnt, 48);
        chk("t1_rdata", rsp_rdata, 16'h0000);
        repeat (3) @(negedge clk);

        // 2: read 0x0012, RAM returns 0xA55A
        miso_word = 16'hA55A;
        send(1'b0, 16'h0012, 16'h0000);
        wait_rsp();
        chk("t2_latency", rsp_edge - acc_q[$] + 1, 97);
        chk("t2_frame", last_rx, 48'h0300_0024_0000);
        chk("t2_rdata", rsp_rdata, 16'hA55A);
        repeat (2) @(negedge clk);

        // 3: read top word address -> byte address 0x01FFFE
        miso_word = 16'h1234;
        send(1'b0, 16'hFFFF, 16'h0000);
        wait_rsp();
        chk("t3_frame", last_rx, 48'h0301_FFFE_0000);
        chk("t3_rdata", rsp_rdata, 16'h1234);
        repeat (2) @(negedge clk);

        // 4: back-to-back with req_valid held high
        miso_word = 16'h0F0F;
        n0 = acc_q.size();
        req_write = 1'b1; req_addr = 16'h0100; req_wdata = 16'h1357; req_valid = 1'b1;
        wait_acc(n0 + 1, "t4_accept1");
        req_write = 1'b0; req_addr = 16'h0200; req_wdata = 16'h0000;
        wait_acc(n0 + 2, "t4_accept2");
        req_valid = 1'b0;
        if (acc_q.size() >= 2) chk("t4_accept_gap", acc_q[$] - acc_q[$-1], 98);
        wait_rsp();
        chk("t4_cs_gap", last_gap, 2);
        chk("t4_frame", last_rx, 48'h0300_0400_0000);
        chk("t4_rdata", rsp_rdata, 16'h0F0F);
        repeat (2) @(negedge clk);

        // 5: reset during data phase of a read
        miso_word = 16'hFFFF;
        send(1'b0, 16'h0040, 16'h0000);
        repeat (40) @(negedge clk);
        #2;
        abort = 1'b1;
        rst = 1'b1;
        #1;
        chk("t5_select_async", spi_select, 1);
        chk("t5_sck_async", spi_clk, 0);
        chk("t5_rdata_async", rsp_rdata, 0);
        chk("t5_rsp_valid_async", rsp_valid, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        chk("t5_ready_after", req_ready, 1);
        chk("t5_busy_after", busy, 0);

        // recovery read after the abort
        miso_word = 16'h8001;
        send(1'b0, 16'h0001, 16'h0000);
        wait_rsp();
        chk("t6_frame", last_rx, 48'h0300_0002_0000);
        chk("t6_sck_rises", last_cnt, 48);
        chk("t6_rdata", rsp_rdata, 16'h8001);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
